// File: rtl/recseq_pkg.sv
// Shared types, defaults and helpers for the recurrence sequencer.
package recseq_pkg;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefDepth   = 16;
    localparam int unsigned DefTickDiv = 30000000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Index width for a table of 'value' entries (minimum 1 bit).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/recseq_regfile.sv
// Term storage: DEPTH x WIDTH, term write port plus seed loads into entries 0/1,
// two async read ports for the recurrence operands and one registered readback port.
module recseq_regfile
    import recseq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_seed_a_we,
    input  logic                    i_seed_b_we,
    input  logic [WIDTH-1:0]        i_seed,
    input  logic                    i_we,
    input  logic [clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic [clog2(DEPTH)-1:0] i_raddr_a,
    input  logic [clog2(DEPTH)-1:0] i_raddr_b,
    input  logic [clog2(DEPTH)-1:0] i_rd_idx,
    output logic [WIDTH-1:0]        o_rdata_a,
    output logic [WIDTH-1:0]        o_rdata_b,
    output logic [WIDTH-1:0]        o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem     <= '{default: '0};
            r_rd_data <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (i_seed_a_we) begin
                r_mem[0] <= i_seed;
            end
            if (i_seed_b_we) begin
                r_mem[1] <= i_seed;
            end
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/recurrence_sequencer.sv
// Generates mem[k] = mem[k-1] + mem[k-2] for k = 2..DEPTH-1, one term every TICK_DIV cycles.
// Define RECSEQ_SATURATE_EN to clamp overflowing terms to 2^WIDTH-1 instead of wrapping.
module recurrence_sequencer
    import recseq_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned TICK_DIV = DefTickDiv
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    SeedA_n,
    input  logic                    SeedB_n,
    input  logic [WIDTH-1:0]        Seed,
    input  logic                    Start,
    input  logic [clog2(DEPTH)-1:0] RdIdx,
    output logic [WIDTH-1:0]        RdData,
    output logic [WIDTH-1:0]        Term,
    output logic [clog2(DEPTH)-1:0] TermIdx,
    output logic                    TermValid,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Overflow
);

    localparam int unsigned     IdxW     = clog2(DEPTH);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DEPTH - 1);
    localparam logic [31:0]     TickLast = 32'(TICK_DIV - 1);

    state_e          r_state, w_state_d;
    logic [31:0]     r_tick, w_tick_d;
    logic [IdxW-1:0] r_k, w_k_d;
    logic            r_overflow, w_overflow_d;
    logic [WIDTH-1:0] r_term;
    logic [IdxW-1:0]  r_term_idx;
    logic             r_term_valid;

    logic             w_seed_load, w_tick_hit, w_write;
    logic [WIDTH-1:0] w_km1, w_km2, w_term;
    logic [WIDTH:0]   w_sum;

    recseq_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .i_clk       (Clock),
        .i_rst_n     (Reset),
        .i_seed_a_we (!SeedA_n),
        .i_seed_b_we (!SeedB_n),
        .i_seed      (Seed),
        .i_we        (w_write),
        .i_waddr     (r_k),
        .i_wdata     (w_term),
        .i_raddr_a   (r_k - IdxW'(1)),
        .i_raddr_b   (r_k - IdxW'(2)),
        .i_rd_idx    (RdIdx),
        .o_rdata_a   (w_km1),
        .o_rdata_b   (w_km2),
        .o_rd_data   (RdData)
    );

    assign w_seed_load = !SeedA_n || !SeedB_n;
    assign w_tick_hit  = (r_tick == TickLast);
    // A seed load in the same cycle abandons the run, so it also suppresses the term write.
    assign w_write     = (r_state == StRun) && w_tick_hit && !w_seed_load;
    assign w_sum       = {1'b0, w_km1} + {1'b0, w_km2};
`ifdef RECSEQ_SATURATE_EN
    assign w_term      = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
    assign w_term      = w_sum[WIDTH-1:0];
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= StIdle;
            r_tick     <= '0;
            r_k        <= IdxW'(2);
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_tick     <= w_tick_d;
            r_k        <= w_k_d;
            r_overflow <= w_overflow_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_tick_d     = r_tick;
        w_k_d        = r_k;
        w_overflow_d = r_overflow;
        if (w_seed_load) begin
            w_state_d    = StIdle;
            w_overflow_d = 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (Start) begin
                        w_state_d    = StRun;
                        w_tick_d     = '0;
                        w_k_d        = IdxW'(2);
                        w_overflow_d = 1'b0;
                    end
                end
                StRun: begin
                    if (w_tick_hit) begin
                        w_tick_d = '0;
                        w_k_d    = r_k + IdxW'(1);
                        if (w_sum[WIDTH]) begin
                            w_overflow_d = 1'b1;
                        end
                        if (r_k == LastIdx) begin
                            w_state_d = StDone;
                        end
                    end else begin
                        w_tick_d = r_tick + 32'd1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_term       <= '0;
            r_term_idx   <= '0;
            r_term_valid <= 1'b0;
        end else begin
            r_term_valid <= w_write;
            if (w_write) begin
                r_term     <= w_term;
                r_term_idx <= r_k;
            end
        end
    end

    assign Term      = r_term;
    assign TermIdx   = r_term_idx;
    assign TermValid = r_term_valid;
    assign Busy      = (r_state == StRun);
    assign Done      = (r_state == StDone);
    assign Overflow  = r_overflow;

endmodule
